// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma key-entry path.
// Latency: n/a (declarations only).
// Backpressure: n/a; consumers sample letter/letter_valid every cycle.
package enigma_pkg;

   localparam int LETTER_W   = 5;
   localparam int LETTER_MAX = 25;

   typedef logic [LETTER_W-1:0] letter_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      WAIT_REL
   } key_state_t;

   // A code is a letter only when it falls within A..Z.
   function automatic logic letter_in_range(input letter_t code);
      return code <= letter_t'(LETTER_MAX);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw enter button and debounces it into a stable level.
// Latency: 2 sync cycles plus DEBOUNCE_CYCLES before btn_db follows btn.
// Backpressure: none; edges shorter than DEBOUNCE_CYCLES are dropped.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic btn_db
);

   logic             r_btn_sync1;
   logic             r_btn_s;
   logic             r_btn_db;
   logic [CNT_W-1:0] r_cnt;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_sync1 <= 1'b0;
         r_btn_s     <= 1'b0;
      end else begin
         r_btn_sync1 <= btn;
         r_btn_s     <= r_btn_sync1;
      end
   end

   // Count consecutive cycles of disagreement; flip the level once it has lasted long enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_btn_db <= 1'b0;
      end else if (r_btn_s == r_btn_db) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         r_cnt    <= '0;
         r_btn_db <= ~r_btn_db;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign btn_db = r_btn_db;

endmodule

// File: rtl/enigma_key_entry.sv
// Key entry: sync letter switches, debounce enter, range-check, emit a one-cycle strobe.
// Latency: DEBOUNCE_CYCLES + 3 cycles from raw button rise to letter_valid/key_err.
// Backpressure: none; one accept per debounced press, A ignored while held.
module enigma_key_entry
   import enigma_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] A,
   input  logic       btn,
   output logic [4:0] letter,
   output logic       letter_valid,
   output logic       key_err,
   output logic       busy,
   output logic [7:0] key_count
);

   letter_t    r_a_sync1;
   letter_t    r_a_s;
   key_state_t r_state;
   key_state_t w_next_state;
   logic       w_take;
   logic       w_in_range;
   logic       w_btn_db;
   letter_t    r_letter;
   logic       r_letter_valid;
   logic       r_key_err;
   logic [7:0] r_key_count;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .btn_db (w_btn_db)
   );

   // Two-flop synchronizer for the letter switches (bus is quasi-static during a press).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sync1 <= '0;
         r_a_s     <= '0;
      end else begin
         r_a_sync1 <= A;
         r_a_s     <= r_a_sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next state; w_take marks the edge entering ACCEPT, where the switch value is captured.
   // btn_db can only be high in IDLE after a fresh rise, since WAIT_REL waits for it to drop.
   always_comb begin
      w_next_state = r_state;
      w_take       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_btn_db) begin
               w_next_state = ACCEPT;
               w_take       = 1'b1;
            end
         end
         ACCEPT:   w_next_state = WAIT_REL;
         WAIT_REL: if (!w_btn_db) w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   assign w_in_range = letter_in_range(r_a_s);

   // Output registers: strobes are high exactly during the ACCEPT cycle, letter updates with them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_letter       <= '0;
         r_letter_valid <= 1'b0;
         r_key_err      <= 1'b0;
         r_key_count    <= '0;
      end else begin
         r_letter_valid <= w_take & w_in_range;
         r_key_err      <= w_take & ~w_in_range;
         if (w_take && w_in_range) begin
            r_letter    <= r_a_s;
            r_key_count <= r_key_count + 8'd1;
         end
      end
   end

   assign letter       = r_letter;
   assign letter_valid = r_letter_valid;
   assign key_err      = r_key_err;
   assign key_count    = r_key_count;
   assign busy         = (r_state != IDLE);

endmodule
